// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//
// Multi-cycle EX-stage ALU. It keeps the single-cycle logic and arithmetic ops
// of the original 32-bit ALU but registers their results. It also adds
// MIPS-style iterative multiply and divide into internal HI/LO registers, and
// MFHI/MFLO readout of those registers.
//
// Handshake (valid/ready):
//   - A request is "start" and is ready to be taken whenever busy=0.
//   - start=1 while busy=1 is ignored; nothing is queued.
//   - op, a and b are captured at the accepting edge.
//   - done pulses for exactly one cycle per accepted request.
//   - z and zero stay valid and held from that done pulse until the next done.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        request strobe, sampled only when busy=0
//   op[3:0]      operation code, sampled with start
//   a, b         operands (dividend/multiplicand, divisor/multiplier)
//   busy         high from the cycle after a mult/div accept until done
//   done         one-cycle result-valid pulse
//   z            registered result
//   zero         registered (z == 0)
//   hi, lo       HI/LO registers (product halves, or remainder/quotient)
//   div_by_zero  pulses with done when DIV/DIVU is issued with b == 0
// -----------------------------------------------------------------------------
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // Iteration counter width; derived from WIDTH only.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MFHI  = 4'b0011;
    localparam logic [3:0] OP_MFLO  = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t state;

    logic [CNT_W-1:0] cnt;
    // Shared iteration datapath.
    //   Multiply: acc is the running upper half of the product; sh shifts the
    //             multiplier out at the bottom while product bits enter at the
    //             top.
    //   Divide:   acc is the partial remainder; sh shifts the dividend out at
    //             the top while quotient bits enter at the bottom.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] dvs;      // multiplicand or divisor magnitude
    logic             is_div;   // FIN selects the divide or the multiply writeback
    logic             neg_q;    // negate product / quotient at FIN
    logic             neg_r;    // negate remainder at FIN (sign of dividend)

    // ------------------------------------------------------------------------
    // Operand magnitudes. Only the signed ops (MULT, DIV) take |x|.
    // Negating the most-negative value yields 2^(WIDTH-1), which is exactly
    // its magnitude when read as unsigned.
    // ------------------------------------------------------------------------
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;
    end

    // ------------------------------------------------------------------------
    // Single-cycle results
    // ------------------------------------------------------------------------
    logic             slt_bit;
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        slt_bit = $signed(a) < $signed(b);
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_NOR:  alu_res = ~(a | b);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // One shift-add multiply step: add the multiplicand into the upper half
    // when the current multiplier bit is set, then shift the whole 2*WIDTH
    // value right by one. The carry out of the add becomes the new top bit.
    // ------------------------------------------------------------------------
    logic [WIDTH:0] mul_sum;

    always_comb begin
        mul_sum = {1'b0, acc} + (sh[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});
    end

    // ------------------------------------------------------------------------
    // One restoring-divide step: shift the next dividend bit into the partial
    // remainder, then try to subtract the divisor. A borrow (top bit set)
    // means the trial failed, so the shifted remainder is kept instead.
    // ------------------------------------------------------------------------
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ok;

    always_comb begin
        div_shift = {acc, sh[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvs};
        div_ok    = ~div_diff[WIDTH];
    end

    // ------------------------------------------------------------------------
    // Final sign fix-up. The quotient takes sign(a)^sign(b) and the remainder
    // takes sign(a). Most-negative / -1 gives a magnitude quotient of
    // 2^(WIDTH-1); negating it wraps back to the most-negative value.
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    always_comb begin
        prod_mag = {acc, sh};
        prod_fin = neg_q ? (~prod_mag + 1'b1) : prod_mag;
        quo_fin  = neg_q ? (~sh + 1'b1) : sh;
        rem_fin  = neg_r ? (~acc + 1'b1) : acc;
        if (is_div) begin
            fin_hi = rem_fin;
            fin_lo = quo_fin;
        end else begin
            fin_hi = prod_fin[2*WIDTH-1:WIDTH];
            fin_lo = prod_fin[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and all registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            sh          <= '0;
            dvs         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            z           <= '0;
            zero        <= 1'b1;
            hi          <= '0;
            lo          <= '0;
        end else begin
            // Pulse outputs default low; each accepted op raises them once.
            done        <= 1'b0;
            div_by_zero <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state  <= S_MUL;
                                busy   <= 1'b1;
                                cnt    <= '0;
                                acc    <= '0;
                                sh     <= b_mag;
                                dvs    <= a_mag;
                                is_div <= 1'b0;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (b == '0) begin
                                    // No iteration; HI/LO keep their values.
                                    done        <= 1'b1;
                                    div_by_zero <= 1'b1;
                                    z           <= '0;
                                    zero        <= 1'b1;
                                end else begin
                                    state  <= S_DIV;
                                    busy   <= 1'b1;
                                    cnt    <= '0;
                                    acc    <= '0;
                                    sh     <= a_mag;
                                    dvs    <= b_mag;
                                    is_div <= 1'b1;
                                    neg_q  <= a_neg ^ b_neg;
                                    neg_r  <= a_neg;
                                end
                            end
                            default: begin
                                z    <= alu_res;
                                zero <= (alu_res == '0);
                                done <= 1'b1;
                            end
                        endcase
                    end
                end

                S_MUL: begin
                    acc <= mul_sum[WIDTH:1];
                    sh  <= {mul_sum[0], sh[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= S_FIN;
                    end
                end

                S_DIV: begin
                    if (div_ok) begin
                        acc <= div_diff[WIDTH-1:0];
                        sh  <= {sh[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= div_shift[WIDTH-1:0];
                        sh  <= {sh[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= S_FIN;
                    end
                end

                S_FIN: begin
                    hi    <= fin_hi;
                    lo    <= fin_lo;
                    z     <= '0;
                    zero  <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, multi-cycle successor to the datapath's single-cycle 32-bit ALU.
- Keeps the existing logic and arithmetic op encodings and registers their results.
- Adds iterative MIPS-style multiply and divide into internal HI/LO registers, plus MFHI/MFLO readout, under a start/busy/done handshake.
- Sits in the EX stage; control stalls while busy=1.

Parameters:
- WIDTH, 32: operand, result, HI and LO width; legal range 8..64.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  4  operation code, sampled with start
- a  input  WIDTH  operand A (dividend / multiplicand), sampled with start
- b  input  WIDTH  operand B (divisor / multiplier), sampled with start
- busy  output  1  high from the cycle after accept until done
- done  output  1  one-cycle pulse: result valid
- z  output  WIDTH  registered result, held until the next done
- zero  output  1  registered; equals (z==0), updates with z
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)
- div_by_zero  output  1  pulses with done when DIV/DIVU has b==0

Behaviour:
- Reset: synchronous. At any edge with reset=1, every output and register goes to 0 (busy, done, z, hi, lo, div_by_zero, counter, state=IDLE); zero=1. Reset aborts an operation in flight, and hi/lo are not updated.
- Op codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (signed), NOR 1100
  - MFHI 0011, MFLO 0100
  - MULT 1000, MULTU 1001, DIV 1010, DIVU 1011
  - Any other code: z=0, done after 1 cycle.
- ADD/SUB: modulo 2^WIDTH; no overflow flag.
- SLT: z = {0..., signed(a)<signed(b)}.
- Accept: when start=1 and busy=0, op, a and b are captured at the edge. If start=1 while busy=1, it is ignored.
- States: IDLE, MUL, DIV, FIN.
- Single-cycle ops (logic, ADD, SUB, SLT, MFHI, MFLO, undefined):
  - Accept edge writes z/zero and sets done=1 for the next cycle.
  - State stays IDLE; busy stays 0.
  - Back-to-back start every cycle is allowed.
- MULT/MULTU, IDLE->MUL:
  - Take operand magnitudes (signed ops only); 2*WIDTH-bit shift-add, one bit per cycle, WIDTH cycles.
  - MUL->FIN; FIN applies sign ((a^b) sign bit) and writes {hi,lo}, then goes to IDLE with done=1.
- DIV/DIVU, IDLE->DIV:
  - Restoring division on magnitudes, WIDTH cycles, then DIV->FIN.
  - Quotient truncates toward zero; remainder takes the sign of the dividend. lo=quotient, hi=remainder.
  - Most-negative / -1 gives lo=most-negative, hi=0, with no flag.
- Latency for mult/div: accept edge E. busy=1 in cycles E+1 .. E+WIDTH+1. hi/lo written and done=1 in cycle E+WIDTH+2, where busy=0. A new start is accepted in that same done cycle.
- z for MULT/MULTU/DIV/DIVU: z=0, zero=1 at done.
- Divide by zero (b==0): no iteration. done=1 and div_by_zero=1 in cycle E+1; hi/lo unchanged; z=0.
- MFHI/MFLO issued in the done cycle of a mult/div return the new hi/lo.
- done and div_by_zero are high for exactly one cycle per accepted op.

Test Plan:
- Reset, then ADD a=7, b=0xFFFFFFF9 -> done in cycle 1, z=0, zero=1. Then SLT a=0xFFFFFFFF, b=1 -> z=1, zero=0.
- MULT a=-3 (0xFFFFFFFD), b=5 -> busy for 33 cycles; done at E+34; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1. Follow with MFLO -> z=3, then MFHI -> z=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> done and div_by_zero in cycle E+1; hi/lo keep their prior values.
- Start MULT, pulse start with ADD at E+5 -> ignored, with only one done (at E+34). Assert reset at E+10 -> busy=0, hi=lo=0, no done pulse.
- WIDTH=8 instance: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01, done at E+10. Streaming AND ops every cycle -> one done per cycle.
